mines_game_ctrl: RTL and testbench

Game-flow controller for the 4x4 minesweeper board. It sequences the mine placer (init pulse, wait for done), owns the player cursor and the revealed-tile mask, resolves reveal requests against a latched copy of the mine map, and counts adjacent mines serially. It streams per-tile counts to the frame-buffer writer. It sits between the key/switch inputs and the `mine_placement` / VGA display blocks in the top level, and replaces the direct key-to-`init_game` connection.

---
 rtl/mines_pkg.sv | 46 ++++
 rtl/mines_neighbor_addr.sv | 29 ++
 rtl/mines_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_mines_game_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mines_pkg.sv
// mines_pkg: shared definitions for the 4x4 minesweeper game-flow controller.
//   - state_t     : controller FSM encoding (also driven onto the LED state port)
//   - GRID_DIM    : board side length; NUM_TILES = GRID_DIM*GRID_DIM
//   - dir_t       : mv_dir codes
//   - nb_dr/nb_dc : neighbor offset table, k = 0..7 in raster order around the center
package mines_pkg;

  localparam int GRID_DIM  = 4;
  localparam int NUM_TILES = GRID_DIM * GRID_DIM;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLACE = 3'd1,
    S_PLAY  = 3'd2,
    S_COUNT = 3'd3,
    S_WRITE = 3'd4,
    S_LOST  = 3'd5,
    S_WON   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Row offset of neighbor k: (-1,-1),(-1,0),(-1,1),(0,-1),(0,1),(1,-1),(1,0),(1,1)
  function automatic logic signed [2:0] nb_dr(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: nb_dr = -3'sd1;
      3'd3, 3'd4:       nb_dr = 3'sd0;
      default:          nb_dr = 3'sd1;
    endcase
  endfunction

  // Column offset of neighbor k, same ordering as nb_dr
  function automatic logic signed [2:0] nb_dc(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: nb_dc = -3'sd1;
      3'd1, 3'd6:       nb_dc = 3'sd0;
      default:          nb_dc = 3'sd1;
    endcase
  endfunction

endpackage

// File: rtl/mines_neighbor_addr.sv
// mines_neighbor_addr: combinational neighbor address generator.
// Ports:
//   center    in  IDX_W : tile index whose neighborhood is scanned
//   k         in  3     : neighbor number 0..7 (order from mines_pkg offset table)
//   in_bounds out 1     : neighbor lies on the board
//   nb_idx    out IDX_W : neighbor tile index (0 when off-board)
module mines_neighbor_addr #(
  parameter int GRID_DIM = 4,
  parameter int IDX_W    = $clog2(GRID_DIM * GRID_DIM)
) (
  input  logic [IDX_W-1:0] center,
  input  logic [2:0]       k,
  output logic             in_bounds,
  output logic [IDX_W-1:0] nb_idx
);
  import mines_pkg::*;

  int row, col, nrow, ncol;

  always_comb begin
    row       = int'(center) / GRID_DIM;
    col       = int'(center) % GRID_DIM;
    nrow      = row + int'(nb_dr(k));
    ncol      = col + int'(nb_dc(k));
    in_bounds = (nrow >= 0) && (nrow < GRID_DIM) && (ncol >= 0) && (ncol < GRID_DIM);
    nb_idx    = in_bounds ? IDX_W'(nrow * GRID_DIM + ncol) : '0;
  end

endmodule

// File: rtl/mines_game_ctrl.sv
// mines_game_ctrl: game-flow controller for the minesweeper board.
// Sequences the mine placer, owns cursor and revealed mask, resolves reveals
// against a latched mine map and serially counts adjacent mines.
// Ports:
//   clk, rst (async, active-low)
//   start          in  : level request, rising edge starts a new game
//   mv_req/mv_dir  in  : one-cycle move pulse and direction
//   reveal_req     in  : one-cycle reveal of the tile under the cursor
//   mine_map       in  : placer output, bit i = mine at tile i
//   placement_done in  : placer done level
//   init_game      out : one-cycle pulse to the placer
//   cursor         out : current tile index
//   revealed       out : revealed-tile mask
//   adj_wr_en/adj_wr_idx/adj_wr_cnt out : per-tile adjacent-count write strobe
//   state          out : FSM encoding
//   game_over/game_won out : high in LOST / WON
module mines_game_ctrl #(
  parameter int GRID_DIM = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   mv_req,
  input  logic [1:0]                             mv_dir,
  input  logic                                   reveal_req,
  input  logic [GRID_DIM*GRID_DIM-1:0]           mine_map,
  input  logic                                   placement_done,
  output logic                                   init_game,
  output logic [$clog2(GRID_DIM*GRID_DIM)-1:0]   cursor,
  output logic [GRID_DIM*GRID_DIM-1:0]           revealed,
  output logic                                   adj_wr_en,
  output logic [$clog2(GRID_DIM*GRID_DIM)-1:0]   adj_wr_idx,
  output logic [3:0]                             adj_wr_cnt,
  output logic [2:0]                             state,
  output logic                                   game_over,
  output logic                                   game_won
);
  import mines_pkg::*;

  localparam int N_TILES = GRID_DIM * GRID_DIM;
  localparam int IDX_W   = $clog2(N_TILES);
  localparam logic [IDX_W-1:0] DIM     = IDX_W'(GRID_DIM);
  localparam logic [IDX_W-1:0] LAST_RC = IDX_W'(GRID_DIM - 1);

  state_t             state_q, state_d;
  logic               start_q, start_edge, start_ok;
  logic [N_TILES-1:0] map_q;
  logic [2:0]         nb_k;
  logic [3:0]         acc;
  logic [IDX_W-1:0]   cursor_mv, cur_row, cur_col, nb_idx;
  logic               nb_in, nb_hit, reveal_ok, all_safe_revealed;

  mines_neighbor_addr #(.GRID_DIM(GRID_DIM), .IDX_W(IDX_W)) u_nb (
    .center    (cursor),
    .k         (nb_k),
    .in_bounds (nb_in),
    .nb_idx    (nb_idx)
  );

  assign start_edge = start & ~start_q;
  // Edges arriving while placing or counting are dropped, not queued.
  assign start_ok   = (state_q == S_IDLE) || (state_q == S_PLAY) ||
                      (state_q == S_LOST) || (state_q == S_WON);
  assign nb_hit     = nb_in & map_q[nb_idx];
  assign reveal_ok  = reveal_req & ~revealed[cursor];
  assign all_safe_revealed = ($countones(revealed) == (N_TILES - $countones(map_q)));
  assign cur_row    = cursor / DIM;
  assign cur_col    = cursor % DIM;

  // Saturating cursor step, no wrap at the board edges
  always_comb begin
    cursor_mv = cursor;
    case (mv_dir)
      DIR_UP:    if (cur_row != '0)     cursor_mv = cursor - DIM;
      DIR_DOWN:  if (cur_row != LAST_RC) cursor_mv = cursor + DIM;
      DIR_LEFT:  if (cur_col != '0)     cursor_mv = cursor - IDX_W'(1);
      DIR_RIGHT: if (cur_col != LAST_RC) cursor_mv = cursor + IDX_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // init_game is high only in the first PLACE cycle, so it doubles as the
  // marker for ignoring a possibly stale placement_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_LOST, S_WON: if (start_edge) state_d = S_PLACE;
      S_PLACE: if (placement_done && !init_game) state_d = S_PLAY;
      S_PLAY: begin
        if (start_edge)     state_d = S_PLACE;
        else if (reveal_ok) state_d = map_q[cursor] ? S_LOST : S_COUNT;
      end
      S_COUNT: if (nb_k == 3'd7) state_d = S_WRITE;
      S_WRITE: state_d = all_safe_revealed ? S_WON : S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b0;
      init_game <= 1'b0;
      cursor    <= '0;
      revealed  <= '0;
      map_q     <= '0;
      nb_k      <= '0;
      acc       <= '0;
    end else begin
      start_q   <= start;
      init_game <= 1'b0;
      if (start_edge && start_ok) begin
        init_game <= 1'b1;
        revealed  <= '0;
        cursor    <= '0;
      end else begin
        case (state_q)
          S_PLACE: if (placement_done && !init_game) map_q <= mine_map;
          S_PLAY: begin
            // A reveal always takes precedence; a coincident move is dropped.
            if (reveal_req) begin
              if (reveal_ok) begin
                revealed[cursor] <= 1'b1;
                nb_k             <= '0;
                acc              <= '0;
              end
            end else if (mv_req) begin
              cursor <= cursor_mv;
            end
          end
          S_COUNT: begin
            acc  <= acc + 4'(nb_hit);
            nb_k <= nb_k + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign adj_wr_en  = (state_q == S_WRITE);
  assign adj_wr_idx = adj_wr_en ? cursor : '0;
  assign adj_wr_cnt = adj_wr_en ? acc : '0;
  assign state      = state_q;
  assign game_over  = (state_q == S_LOST);
  assign game_won   = (state_q == S_WON);

endmodule

// File: tb/tb_mines_game_ctrl.sv
// Testbench for mines_game_ctrl: directed scenarios plus randomized games
// against a behavioural board model; adjacency writes go through a scoreboard.
module tb_mines_game_ctrl;
  import mines_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, mv_req = 1'b0, reveal_req = 1'b0, placement_done = 1'b0;
  logic [1:0]  mv_dir = 2'b00;
  logic [15:0] mine_map = 16'h0;
  logic        init_game, adj_wr_en, game_over, game_won;
  logic [3:0]  cursor, adj_wr_idx, adj_wr_cnt;
  logic [15:0] revealed;
  logic [2:0]  state;

  mines_game_ctrl #(.GRID_DIM(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mv_req(mv_req), .mv_dir(mv_dir),
    .reveal_req(reveal_req), .mine_map(mine_map), .placement_done(placement_done),
    .init_game(init_game), .cursor(cursor), .revealed(revealed),
    .adj_wr_en(adj_wr_en), .adj_wr_idx(adj_wr_idx), .adj_wr_cnt(adj_wr_cnt),
    .state(state), .game_over(game_over), .game_won(game_won)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the game
  logic [15:0] m_map, m_rev;
  int          m_cur;
  state_t      m_st;

  typedef struct { int idx; int cnt; int due; } wr_t;
  wr_t sb[$];
  wr_t e;

  int n_tests = 0, n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic int adj_count(logic [15:0] map, int t);
    int r, c, n;
    r = t / 4; c = t % 4; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
          n += int'(map[(r + dr) * 4 + c + dc]);
    return n;
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (adj_wr_en) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: idx %0d cnt %0d at cycle %0d, no write expected",
                 adj_wr_idx, adj_wr_cnt, cyc);
      end else begin
        e = sb.pop_front();
        chk("wr_idx", int'(adj_wr_idx), e.idx);
        chk("wr_cnt", int'(adj_wr_cnt), e.cnt);
        chk("wr_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_status(string tag);
    chk({tag, ".cursor"}, int'(cursor), m_cur);
    chk({tag, ".revealed"}, int'(revealed), int'(m_rev));
    chk({tag, ".state"}, int'(state), int'(m_st));
    chk({tag, ".game_over"}, int'(game_over), int'(m_st == S_LOST));
    chk({tag, ".game_won"}, int'(game_won), int'(m_st == S_WON));
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".init_game"}, int'(init_game), 0);
    chk({tag, ".cursor"}, int'(cursor), 0);
    chk({tag, ".revealed"}, int'(revealed), 0);
    chk({tag, ".adj_wr_en"}, int'(adj_wr_en), 0);
    chk({tag, ".adj_wr_idx"}, int'(adj_wr_idx), 0);
    chk({tag, ".adj_wr_cnt"}, int'(adj_wr_cnt), 0);
    chk({tag, ".state"}, int'(state), int'(S_IDLE));
    chk({tag, ".game_over"}, int'(game_over), 0);
    chk({tag, ".game_won"}, int'(game_won), 0);
  endtask

  // placement_done is held high from the start, so the first PLACE cycle must ignore it
  task automatic new_game(logic [15:0] map);
    mine_map = map; placement_done = 1'b1; start = 1'b1;
    tick();
    m_rev = '0; m_cur = 0; m_st = S_PLACE;
    chk("init_pulse", int'(init_game), 1);
    check_status("place");
    start = 1'b0;
    tick();
    chk("init_one_cycle", int'(init_game), 0);
    check_status("stale_done");
    tick();
    m_map = map; m_st = S_PLAY;
    check_status("play_entry");
    placement_done = 1'b0;
    mine_map = 16'($urandom);
  endtask

  task automatic move(logic [1:0] d);
    int r, c;
    mv_dir = d; mv_req = 1'b1;
    tick();
    mv_req = 1'b0;
    if (m_st == S_PLAY) begin
      r = m_cur / 4; c = m_cur % 4;
      case (d)
        2'b00: if (r > 0) r--;
        2'b01: if (r < 3) r++;
        2'b10: if (c > 0) c--;
        2'b11: if (c < 3) c++;
      endcase
      m_cur = r * 4 + c;
    end
    check_status("move");
  endtask

  task automatic reveal(bit with_move);
    reveal_req = 1'b1; mv_req = with_move; mv_dir = 2'($urandom);
    tick();
    reveal_req = 1'b0; mv_req = 1'b0;
    if (m_st == S_PLAY && !m_rev[m_cur]) begin
      m_rev[m_cur] = 1'b1;
      if (m_map[m_cur]) begin
        m_st = S_LOST;
        check_status("reveal_mine");
      end else begin
        sb.push_back('{m_cur, adj_count(m_map, m_cur), cyc + 8});
        m_st = S_COUNT;
        check_status("count_entry");
        // Requests during COUNT must be dropped
        for (int i = 0; i < 8; i++) begin
          mv_req = 1'($urandom); reveal_req = 1'($urandom);
          mv_dir = 2'($urandom); start = 1'($urandom);
          tick();
        end
        mv_req = 1'b0; reveal_req = 1'b0; start = 1'b0;
        m_st = S_WRITE;
        check_status("write");
        tick();
        m_st = ($countones(m_rev) == 16 - $countones(m_map)) ? S_WON : S_PLAY;
        check_status("after_write");
      end
    end else begin
      check_status("reveal_ignored");
    end
  endtask

  logic [15:0] rmap;

  initial begin
    m_map = '0; m_rev = '0; m_cur = 0; m_st = S_IDLE;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // Basic game, cursor saturation
    new_game(16'h0023);
    move(2'b00); move(2'b10);
    repeat (5) move(2'b11);
    chk("cursor_right_sat", int'(cursor), 3);
    repeat (5) move(2'b01);
    chk("cursor_down_sat", int'(cursor), 15);
    move(2'b00); move(2'b00);
    repeat (3) move(2'b10);
    chk("cursor_at_4", int'(cursor), 4);
    reveal(1'b0);
    chk("rev_tile4", int'(revealed), 16'h0010);
    reveal(1'b0);
    move(2'b11);
    reveal(1'b0);
    chk("lost_tile5", int'(game_over), 1);
    move(2'b01); reveal(1'b0);

    // All mines except tile 0
    new_game(16'hFFFE);
    reveal(1'b1);
    chk("won_fffe", int'(game_won), 1);

    // Empty board: win after 16 reveals, snake traversal
    new_game(16'h0000);
    for (int t = 0; t < 16; t++) begin
      reveal(t == 0);
      if (t % 4 != 3) move(((t / 4) % 2 == 0) ? 2'b11 : 2'b10);
      else            move(2'b01);
    end
    chk("won_empty", int'(game_won), 1);

    // Reset in the middle of COUNT
    new_game(16'h0023);
    move(2'b11); move(2'b11);
    reveal_req = 1'b1;
    tick();
    reveal_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_zero("mid_count_rst");
    repeat (12) tick();
    rst = 1'b1;
    m_map = '0; m_rev = '0; m_cur = 0; m_st = S_IDLE;
    tick();
    reveal(1'b0);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      rmap = 16'($urandom) & 16'($urandom);
      new_game(rmap);
      for (int op = 0; op < 40 && m_st == S_PLAY; op++) begin
        if ($urandom_range(0, 9) < 6) move(2'($urandom));
        else                          reveal(1'b0);
      end
    end

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
